// File: rtl/pc16_pkg.sv
// Shared widths and address type for the 16-bit program counter and its 4-bit slices.
// Pure declarations; no timing or flow-control behaviour of its own.
package pc16_pkg;

    localparam int PC_WIDTH    = 16;
    localparam int SLICE_WIDTH = 4;
    localparam int NUM_SLICES  = PC_WIDTH / SLICE_WIDTH;
    localparam int BYTE_WIDTH  = 8;

    typedef logic [PC_WIDTH-1:0] pc_addr_t;

endpackage

// File: rtl/counter4_slice.sv
// 4-bit synchronous counter slice with parallel load and enable-style carry out.
// Latency: one CP edge for reset, load or increment; TC is combinational.
// No backpressure: CEP/CET gate counting, the chained TC is an enable and never a clock.
module counter4_slice
    import pc16_pkg::*;
#(
    parameter logic [SLICE_WIDTH-1:0] RESET_VALUE = '0
)
(
    input  logic                   CP,
    input  logic                   MR,
    input  logic                   CEP,
    input  logic                   CET,
    input  logic                   _PE,
    input  logic [SLICE_WIDTH-1:0] D,
    output logic [SLICE_WIDTH-1:0] Q,
    output logic                   TC
);

    always_ff @(posedge CP) begin
        if (MR) begin
            Q <= RESET_VALUE;
        end else if (!_PE) begin
            Q <= D;
        end else if (CEP && CET) begin
            Q <= Q + 4'd1;
        end
    end

    // Carry to the next slice: this slice is enabled and about to roll over.
    assign TC = CET & (Q == {SLICE_WIDTH{1'b1}});

endmodule

// File: rtl/program_counter16.sv
// 16-bit program counter from four ripple-enabled 4-bit slices; jumps via staged high byte.
// Latency: one CP edge per load/increment; TC combinational. Optional OVF under PC_WRAP_DETECT_EN.
// No backpressure: MR > _PE > count each edge; _LDHI stages the high jump byte independently.
module program_counter16
    import pc16_pkg::*;
#(
    parameter pc_addr_t RESET_VALUE = 16'h0000
)
(
    input  logic                  CP,
    input  logic                  MR,
    input  logic                  CEP,
    input  logic                  CET,
    input  logic                  _LDHI,
    input  logic                  _PE,
    input  logic [BYTE_WIDTH-1:0] D,
    output pc_addr_t              Q,
    output logic                  TC
`ifdef PC_WRAP_DETECT_EN
    ,
    output logic                  OVF
`endif
);

    logic [BYTE_WIDTH-1:0] hi;
    pc_addr_t              load_word;
    logic [NUM_SLICES:0]   slice_cet;

    // Jump high byte is held here so the whole address lands in one load edge.
    always_ff @(posedge CP) begin
        if (MR) begin
            hi <= '0;
        end else if (!_LDHI) begin
            hi <= D;
        end
    end

    assign load_word    = {hi, D};
    assign slice_cet[0] = CET;

    genvar i;
    generate
        for (i = 0; i < NUM_SLICES; i++) begin : g_slice
            counter4_slice #(
                .RESET_VALUE (RESET_VALUE[i*SLICE_WIDTH +: SLICE_WIDTH])
            ) u_slice (
                .CP  (CP),
                .MR  (MR),
                .CEP (CEP),
                .CET (slice_cet[i]),
                ._PE (_PE),
                .D   (load_word[i*SLICE_WIDTH +: SLICE_WIDTH]),
                .Q   (Q[i*SLICE_WIDTH +: SLICE_WIDTH]),
                .TC  (slice_cet[i+1])
            );
        end
    endgenerate

    // Top of the carry chain equals CET & (Q == FFFF).
    assign TC = slice_cet[NUM_SLICES];

`ifdef PC_WRAP_DETECT_EN
    always_ff @(posedge CP) begin
        if (MR) begin
            OVF <= 1'b0;
        end else if (_PE && CEP && TC) begin
            OVF <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_program_counter16.sv
// Scoreboard bench for program_counter16: directed plan then random stimulus vs a behavioural model.
// Two instances cover the default and a non-zero reset value.
module tb_program_counter16;

    logic        clk = 1'b0;
    logic        mr = 1'b0, cep = 1'b0, cet = 1'b0, ldhi_n = 1'b1, pe_n = 1'b1;
    logic [7:0]  d = 8'h00;
    logic [15:0] q_a, q_b;
    logic        tc_a, tc_b;
    logic        ovf_a, ovf_b;

    localparam logic [15:0] RV_A = 16'h0000;
    localparam logic [15:0] RV_B = 16'h0100;

    always #5 clk = ~clk;

    program_counter16 #(.RESET_VALUE(RV_A)) dut_a (
        .CP(clk), .MR(mr), .CEP(cep), .CET(cet), ._LDHI(ldhi_n), ._PE(pe_n),
        .D(d), .Q(q_a), .TC(tc_a)
`ifdef PC_WRAP_DETECT_EN
        , .OVF(ovf_a)
`endif
    );

    program_counter16 #(.RESET_VALUE(RV_B)) dut_b (
        .CP(clk), .MR(mr), .CEP(cep), .CET(cet), ._LDHI(ldhi_n), ._PE(pe_n),
        .D(d), .Q(q_b), .TC(tc_b)
`ifdef PC_WRAP_DETECT_EN
        , .OVF(ovf_b)
`endif
    );

`ifndef PC_WRAP_DETECT_EN
    assign ovf_a = 1'b0;
    assign ovf_b = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] qa;
        logic [15:0] qb;
        logic        tca;
        logic        tcb;
        logic        ovfa;
        logic        ovfb;
    } exp_t;

    exp_t  sb[$];
    string sb_name[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: the architectural values the spec describes.
    logic [15:0] m_qa, m_qb;
    logic [7:0]  m_hi;
    logic        m_ovfa, m_ovfb;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] next_q(input logic [15:0] q, input logic [15:0] rv,
                                           input logic r, input logic pn, input logic ce,
                                           input logic ct, input logic [7:0] hi,
                                           input logic [7:0] db);
        if (r)         return rv;
        else if (!pn)  return {hi, db};
        else if (ce && ct) return q + 16'd1;
        else           return q;
    endfunction

    // Drive one cycle of inputs at the falling edge and queue the post-edge expectation.
    task automatic step(input string nm, input logic r, input logic ln, input logic pn,
                        input logic ce, input logic ct, input logic [7:0] db);
        exp_t e;
        mr = r; ldhi_n = ln; pe_n = pn; cep = ce; cet = ct; d = db;
        if (!r && pn && ce && ct && m_qa == 16'hFFFF) m_ovfa = 1'b1;
        if (!r && pn && ce && ct && m_qb == 16'hFFFF) m_ovfb = 1'b1;
        if (r) begin
            m_ovfa = 1'b0;
            m_ovfb = 1'b0;
        end
        m_qa = next_q(m_qa, RV_A, r, pn, ce, ct, m_hi, db);
        m_qb = next_q(m_qb, RV_B, r, pn, ce, ct, m_hi, db);
        if (r)        m_hi = 8'h00;
        else if (!ln) m_hi = db;
        e.qa   = m_qa;
        e.qb   = m_qb;
        e.tca  = ct && (m_qa == 16'hFFFF);
        e.tcb  = ct && (m_qb == 16'hFFFF);
        e.ovfa = m_ovfa;
        e.ovfb = m_ovfb;
        sb.push_back(e);
        sb_name.push_back(nm);
        @(negedge clk);
    endtask

    task automatic jump(input string nm, input logic [15:0] a);
        step({nm, "_hi"}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, a[15:8]);
        step({nm, "_lo"}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, a[7:0]);
    endtask

    // Monitor: the counter presents a new output every edge; compare #1 after it.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e  = sb.pop_front();
                nm = sb_name.pop_front();
                chk({nm, ".q"},  q_a, e.qa);
                chk({nm, ".qb"}, q_b, e.qb);
                chk({nm, ".tc"}, {15'd0, tc_a}, {15'd0, e.tca});
                chk({nm, ".tcb"}, {15'd0, tc_b}, {15'd0, e.tcb});
`ifdef PC_WRAP_DETECT_EN
                chk({nm, ".ovf"},  {15'd0, ovf_a}, {15'd0, e.ovfa});
                chk({nm, ".ovfb"}, {15'd0, ovf_b}, {15'd0, e.ovfb});
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        m_qa = 16'h0000; m_qb = 16'h0000; m_hi = 8'h00; m_ovfa = 1'b0; m_ovfb = 1'b0;
        @(negedge clk);

        // Reset with CET low: Q=RESET_VALUE, TC=0, OVF=0.
        step("reset", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);

        // Two-phase jump.
        step("ldhi12", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h12);
        step("pe34",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h34);

        // Carry across slices 1 and 2.
        jump("ld00fe", 16'h00FE);
        for (int i = 0; i < 3; i++) step("cnt_carry", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00);

        // Enable gating at 0FFF.
        jump("ld0fff", 16'h0FFF);
        step("cep0", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
        step("cep0", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
        step("cet0", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        step("both", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00);

        // Wrap and terminal count.
        jump("ldfffe", 16'hFFFE);
        step("to_ffff", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
        cet = 1'b0;
        #1;
        chk("tc_comb_cet0", {15'd0, tc_a}, 16'd0);
        cet = 1'b1;
        #1;
        chk("tc_comb_cet1", {15'd0, tc_a}, 16'd1);
        step("wrap", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00);

        // Simultaneous events.
        step("ldhiAA", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hAA);
        step("ldhi_pe_55", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55);
        step("pe00", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step("pe_over_cnt", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h77);
        step("mr_over_pe", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h99);

        // Reset mid-jump clears HI.
        step("mid_ldhi", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hC3);
        step("mid_mr",   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        step("mid_pe",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A);

        // Random traffic, biased toward counting with frequent near-wrap jumps.
        for (int i = 0; i < 600; i++) begin
            logic r, ln, pn, ce, ct;
            logic [7:0] db;
            r  = ($urandom_range(0, 39) == 0);
            ln = ($urandom_range(0, 3) != 0);
            pn = ($urandom_range(0, 5) != 0);
            ce = ($urandom_range(0, 4) != 0);
            ct = ($urandom_range(0, 4) != 0);
            db = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
            step("rand", r, ln, pn, ce, ct, db);
        end

        @(negedge clk);
        @(negedge clk);
        chk("sb_drained", 16'(sb.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/program_counter16.md
# program_counter16

16-bit synchronous program counter built from four cascaded 4-bit counter slices with ripple-enable carry chaining. It sits directly upstream of the instruction ROM address bus and is fed by the 8-bit data bus for jumps. The high jump byte is staged in a holding register, then applied atomically with the low byte in one load cycle. This prevents the PC from ever presenting a half-updated address.

## Interface
- RESET_VALUE, default 16'h0000: value loaded into Q on reset.
- CP  in  1  clock; all state changes on rising edge.
- MR  in  1  synchronous reset, active-high.
- CEP  in  1  count enable (parallel); counting requires CEP=1 and CET=1.
- CET  in  1  count enable (trickle); also gates TC.
- _LDHI  in  1  active-low; on a rising CP, captures D into the staging register HI.
- _PE  in  1  active-low parallel load; on a rising CP, Q <= {HI, D}.
- D  in  8  data bus byte.
- Q  out  16  counter value (ROM address).
- TC  out  1  terminal count: CET & (Q==16'hFFFF), combinational.
- OVF  out  1  sticky wrap flag; present only with PC_WRAP_DETECT_EN.

## Operation
- Priority on each rising CP: MR > _PE > count. _LDHI is independent of this priority.
- MR=1:
  - Q <= RESET_VALUE; HI <= 8'h00; OVF <= 0.
  - _LDHI and _PE are ignored in that cycle.
- _PE=0 (MR=0): Q <= {HI, D}. This overrides counting regardless of CEP/CET.
- Count (MR=0, _PE=1, CEP=1, CET=1): Q <= Q+1, modulo 2^16.
  - FFFF wraps to 0000.
- Otherwise Q holds.
- _LDHI=0 (MR=0): HI <= D on the edge.
  - If _PE=0 on the same edge, the load uses the *old* HI (register semantics). The new HI is usable from the next load.
- HI is not observable on any output.
- Slice chaining:
  - Slice n is enabled when CEP=1 and CET=1 and all lower slices read 4'hF.
  - Slice 0 has CET tied to the block CET.
  - Internal carry is an enable, never a clock. All slices share CP.
- TC is purely combinational. It tracks CET and Q with no register stage.
- Asynchronous changes to MR, _PE, _LDHI, CEP, CET or D between edges never alter Q.

## Timing
- Load latency: 1 edge.
  - Jump sequence: edge 1 with _LDHI=0 and D=hi; edge 2 with _PE=0 and D=lo.
  - Q shows the full address after edge 2.
- Count latency: 1 edge per increment.
- Reset value of every output:
  - Q=RESET_VALUE.
  - TC = CET & (RESET_VALUE==FFFF).
  - OVF=0.
- Before the first reset, Q is X. No requirement applies to it.
- Reset mid-jump (after _LDHI, before _PE): HI clears. A following _PE loads {00, D}.
- MR asserted while CP is high: no effect until the next rising edge.

## Configuration
- PC_WRAP_DETECT_EN defined:
  - OVF port exists.
  - OVF <= 1 on any counting edge where Q==FFFF.
  - OVF holds until MR.
  - A _PE load does not clear OVF.
- Undefined: no OVF port and no flag register. All other behaviour is identical.

## Structure
- Package pc16_pkg holds:
  - the constants PC_WIDTH=16, SLICE_WIDTH=4, NUM_SLICES=4, BYTE_WIDTH=8;
  - the typedef pc_addr_t (logic [15:0]).
- Sub-module counter4_slice:
  - 4-bit synchronous counter with ports CP, MR (active-high, sync), CEP, CET, _PE, D[3:0], Q[3:0] and TC.
  - Instantiated four times, with the TC of slice n driving the CET of slice n+1.
- The staging register and OVF logic live in the top module.

## Test plan
- Reset: MR=1, one CP edge -> Q=0000, TC=0 (CET=0), OVF=0. MR=1 with RESET_VALUE=16'h0100 -> Q=0100.
- Jump:
  - _LDHI=0, D=8'h12, one edge -> Q unchanged.
  - Then _LDHI=1, _PE=0, D=8'h34, one edge -> Q=1234.
- Count with carry:
  - Load 00FE, CEP=CET=1, 3 edges -> Q=0101.
  - Confirms the slice 1 and slice 2 carries.
- Enable gating:
  - At Q=0FFF with CEP=0, CET=1 -> 2 edges hold 0FFF.
  - With CEP=1, CET=0 -> hold, TC=0.
  - With both enables high -> Q=1000.
- Wrap and TC:
  - Load FFFE, count 1 -> Q=FFFF, TC=1.
  - CET=0 -> TC=0 immediately.
  - CET=1, one edge -> Q=0000, TC=0, OVF=1 (with PC_WRAP_DETECT_EN).
- Simultaneous events:
  - HI=AA, then _LDHI=0, _PE=0, D=55 on the same edge -> Q=AA55.
  - Then _PE=0, D=00 -> Q=5500.
  - _PE=0 with CEP=CET=1 -> load wins.
  - MR=1 with _PE=0 -> Q=RESET_VALUE.
